// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud-tick divider computation used by the RX (and a future TX) block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_W     = 8;

    // Clock cycles per oversample tick; truncates, so the line rate runs slightly fast.
    function automatic int calc_tick_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    // Returns 1 when the received parity bit disagrees with the data byte.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                             input logic               par_bit,
                                             input logic               odd);
        return (^data) ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bus of uart_rx_byte: serial input plus the byte/strobe outputs.
// parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_byte_if;

    logic       rx;
    logic [7:0] data_receive;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    // master drives the line and consumes received bytes
    modport master (
        output rx,
        input  data_receive,
        input  data_valid,
        input  frame_error,
        input  busy
`ifdef UART_RX_PARITY_EN
        , input parity_error
`endif
    );

    modport slave (
        input  rx,
        output data_receive,
        output data_valid,
        output frame_error,
        output busy
`ifdef UART_RX_PARITY_EN
        , output parity_error
`endif
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with a synchronous phase reset, so a
// receiver can realign tick phase to a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic phase_rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (phase_rst || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, 16x oversampled with mid-bit sampling and a 2-flop synchroniser.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) and the parity_error pulse.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_byte_if.slave bus
);

    localparam int         TICK_DIV = calc_tick_div(CLK_FREQ, BAUD);
    localparam logic [3:0] OS_MID   = 4'(MID_SAMPLE);
    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);

    logic              rx_m, rx_s, rx_d;
    logic              start_edge;
    logic              tick;
    logic              phase_rst;

    rx_state_t         state, state_nxt;
    logic [3:0]        os_cnt, os_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              dv_q, dv_nxt;
    logic              fe_q, fe_nxt;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_nxt;
    logic              pe_q, pe_nxt;
`endif

    // Synchroniser resets to the idle (high) line level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .phase_rst (phase_rst),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_nxt;
            bit_cnt <= bit_nxt;
            sr      <= sr_nxt;
            data_q  <= data_nxt;
            dv_q    <= dv_nxt;
            fe_q    <= fe_nxt;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_nxt;
            pe_q    <= pe_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_cnt;
        sr_nxt    = sr;
        data_nxt  = data_q;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        phase_rst = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_q;
        pe_nxt    = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START;
                    os_nxt    = '0;
                    phase_rst = 1'b1;
                end
            end

            // Mid-start check rejects glitches shorter than half a bit.
            START: begin
                if (tick) begin
                    if (os_cnt == OS_MID) begin
                        os_nxt  = '0;
                        bit_nxt = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        os_nxt = os_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        sr_nxt = {rx_s, sr[DATA_W-1:1]};
                        os_nxt = '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end else begin
                        os_nxt = os_cnt + 4'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        par_nxt   = rx_s;
                        os_nxt    = '0;
                        state_nxt = STOP;
                    end else begin
                        os_nxt = os_cnt + 4'd1;
                    end
                end
            end
`endif

            // Leave at mid-stop-bit so an immediately following start edge is seen.
            STOP: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_nxt    = '0;
                        state_nxt = IDLE;
                        if (!rx_s) begin
                            fe_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_mismatch(sr, par_q, PARITY_ODD)) begin
                            pe_nxt = 1'b1;
`endif
                        end else begin
                            dv_nxt   = 1'b1;
                            data_nxt = sr;
                        end
                    end else begin
                        os_nxt = os_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.data_receive = data_q;
    assign bus.data_valid   = dv_q;
    assign bus.frame_error  = fe_q;
    assign bus.busy         = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = pe_q;
`endif

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial UART receiver that feeds the byte-capture/LED-feedback stage. It samples the asynchronous `rx` pin in the `clk` domain and presents each received byte on `data_receive` with a one-cycle `data_valid` strobe. The frame is 8N1, LSB first. The block uses 16x oversampling, a 2-flop synchroniser and mid-bit sampling, so no bit is lost or shifted and the downstream stage needs no separate `uart_clk`.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; fixed at 16, mid-bit sample at tick 7
TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE), derived local constant, clk cycles per tick (651 at defaults)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rx  in  1  raw serial line, asynchronous, idle high
data_receive  out  8  last correctly framed byte, held until the next good byte
data_valid  out  1  one-clk pulse, data_receive updated in the same cycle
frame_error  out  1  one-clk pulse, stop bit sampled low
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, active-high): state IDLE; data_receive=8'h00; data_valid=0; frame_error=0; busy=0.
- Reset values of internal state: sync flops=1 (idle line), tick counter=0, bit counter=0, shift register=0.
- Synchroniser: two flops on `rx`. All logic uses only the second stage (`rx_s`). A third flop (`rx_d`) is kept for edge detection.
- Tick generator: free-running counter 0..TICK_DIV-1. `tick` pulses when the count equals TICK_DIV-1. The counter is forced to 0 on start-edge detection to phase-align.
- IDLE: a falling edge (rx_d=1, rx_s=0) moves to START and clears the oversample count. A line held low does not retrigger.
- START: on the 8th tick (count 7), sample rx_s.
  - rx_s=0: go to DATA, oversample count=0, bit count=0.
  - rx_s=1: false start (glitch), return to IDLE with no output pulse.
- DATA: every 16th tick, sample rx_s and shift LSB-first (sr <= {rx_s, sr[7:1]}). After the 8th bit, go to STOP.
- STOP: on the 16th tick, sample rx_s.
  - rx_s=1: data_receive <= sr and data_valid=1 for exactly one clk.
  - rx_s=0: frame_error=1 for one clk; data_receive is unchanged.
  - Either way, return to IDLE at mid-stop-bit so a back-to-back start bit is caught.
- Latency: data_valid fires 9.5 bit times plus 2–3 clk after the rx falling edge.
- data_valid and frame_error are never high together. Neither is asserted outside the STOP→IDLE transition.
- Reset mid-frame aborts immediately. The partial byte is discarded and there is no pulse. After reset release, a frame is accepted only after a new falling edge.
- Back-to-back frames (no idle gap) are received without loss.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Parameter PARITY_ODD (default 0 = even) and output port `parity_error` (1 bit, one-clk pulse, reset 0) are added.
  - A PARITY state is inserted between DATA and STOP, sampling the 9th bit.
  - On parity mismatch with a good stop bit: parity_error pulses, data_valid stays low, data_receive is unchanged.
  - If the stop bit is also bad, only frame_error pulses.
- Undefined: no PARITY state, no port, 10-bit 8N1 frame.

Decomposition:
- Package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), the OVERSAMPLE=16 and MID_SAMPLE=7 constants, and the TICK_DIV computation function.
- Sub-module `uart_baud_tick`: parameterised tick divider with a synchronous phase-reset input. It is shareable with a future TX block.
- The FSM, synchroniser and shift register stay in `uart_rx_byte`.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD=10_000, giving TICK_DIV=10 and 160 clk per bit.
- Single frame 8'hA5 (LSB first: 1,0,1,0,0,1,0,1) → one data_valid pulse, data_receive=8'hA5, frame_error=0, pulse ≈1520 clk after the start edge.
- Bytes 8'h01 then 8'h80 back-to-back with no idle → two data_valid pulses with values 01 then 80. This proves bit 0 and bit 7 are not dropped or rotated.
- 40-clk low glitch on idle rx → no pulses, busy returns to 0 by clk 90, data_receive unchanged.
- Frame 8'h3C with stop bit driven 0 → frame_error pulses once, data_valid=0, data_receive keeps the previous value. Holding rx low afterwards causes no retrigger until rx goes high then low.
- rst asserted at bit 4 of a frame → outputs zero asynchronously. A subsequent clean 8'h5A frame is received correctly.
- With UART_RX_PARITY_EN (even parity): frame 8'h07 with parity bit 0 → parity_error pulse, no data_valid. The same frame with parity bit 1 → data_valid, data_receive=8'h07.
